// File: rtl/led_pattern.sv
// LED pattern generator for an active-low LED bank. A prescaler advances
// the pattern by one step per period in rotate, bounce, blink or hold mode.
module led_pattern #(
  parameter int                   WIDTH          = 16,
  parameter int                   COUNT_W        = 27,
  parameter logic [COUNT_W-1:0]   DEFAULT_PERIOD = 27'd38_196_600,
  parameter logic [WIDTH-1:0]     RESET_PATTERN  = 16'hfffe
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_cfg_load,
  input  logic [2:0]         i_cfg_mode,
  input  logic [COUNT_W-1:0] i_cfg_period,
  input  logic [WIDTH-1:0]   i_cfg_seed,
  output logic [WIDTH-1:0]   o_led_out,
  output logic               o_tick
);

  // dir  | meaning
  // LEFT | bounce walking towards LED WIDTH-1
  // RIGHT| bounce walking back towards LED 0
  typedef enum logic { DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1 } dir_t;

  localparam int                 POS_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [POS_W-1:0]   POS_ONE = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_MAX = POS_W'(WIDTH - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  localparam logic [2:0] MODE_ROTL   = 3'd0;
  localparam logic [2:0] MODE_ROTR   = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_BLINK  = 3'd3;

  logic [WIDTH-1:0]   r_led;
  logic               r_tick;
  logic [2:0]         r_mode;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] r_count;
  logic [POS_W-1:0]   r_pos;
  dir_t               r_dir;

  logic [WIDTH-1:0]   w_rotl;
  logic [WIDTH-1:0]   w_rotr;
  logic [POS_W-1:0]   w_pos_inc;
  logic [POS_W-1:0]   w_pos_dec;
  logic               w_step;

  assign w_rotl    = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
  assign w_rotr    = {r_led[0], r_led[WIDTH-1:1]};
  assign w_pos_inc = r_pos + POS_ONE;
  assign w_pos_dec = r_pos - POS_ONE;
  assign w_step    = i_enable && (r_count == r_period);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_led    <= RESET_PATTERN;
      r_tick   <= 1'b0;
      r_mode   <= MODE_ROTL;
      r_period <= DEFAULT_PERIOD;
      r_count  <= '0;
      r_pos    <= '0;
      r_dir    <= DIR_LEFT;
    end else if (i_cfg_load) begin
      // a step landing on the load edge is dropped with the old config
      r_led    <= i_cfg_seed;
      r_tick   <= 1'b0;
      r_mode   <= i_cfg_mode;
      r_period <= i_cfg_period;
      r_count  <= '0;
      r_pos    <= '0;
      r_dir    <= DIR_LEFT;
    end else begin
      r_tick <= w_step;
      if (i_enable) begin
        if (w_step) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
      if (w_step) begin
        case (r_mode)
          MODE_ROTL:  r_led <= w_rotl;
          MODE_ROTR:  r_led <= w_rotr;
          MODE_BLINK: r_led <= ~r_led;
          MODE_BOUNCE: begin
            if (r_dir == DIR_LEFT) begin
              r_led <= w_rotl;
              r_pos <= w_pos_inc;
              if (w_pos_inc == POS_MAX) r_dir <= DIR_RIGHT;
            end else begin
              r_led <= w_rotr;
              r_pos <= w_pos_dec;
              if (w_pos_dec == '0) r_dir <= DIR_LEFT;
            end
          end
          default: r_led <= r_led;
        endcase
      end
    end
  end

  assign o_led_out = r_led;
  assign o_tick    = r_tick;

endmodule

// File: tb/tb_led_pattern.sv
// Bench for led_pattern: step-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_led_pattern;

  localparam int W  = 16;
  localparam int CW = 27;
  localparam int DEF_PERIOD = 38_196_600;
  localparam logic [W-1:0] RST_PAT = 16'hfffe;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cfg_load;
  logic [2:0]    cfg_mode;
  logic [CW-1:0] cfg_period;
  logic [W-1:0]  cfg_seed;
  logic [W-1:0]  led_out;
  logic          tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_cfg_load  (cfg_load),
    .i_cfg_mode  (cfg_mode),
    .i_cfg_period(cfg_period),
    .i_cfg_seed  (cfg_seed),
    .o_led_out   (led_out),
    .o_tick      (tick)
  );

  always #5 clk = ~clk;

  // Reference: the pattern is the seed transformed by the number of steps
  // taken since the last load/reset.
  logic [W-1:0] m_seed;
  int           m_mode;
  int           m_period;
  int           m_count;
  int           m_k;
  bit           m_tick;
  bit           m_valid = 0;

  function automatic logic [W-1:0] rot_left(logic [W-1:0] x, int n);
    logic [W-1:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[W-2:0], y[W-1]};
    return y;
  endfunction

  function automatic logic [W-1:0] model_led();
    int b;
    case (m_mode)
      0: return rot_left(m_seed, m_k % W);
      1: return rot_left(m_seed, (W - (m_k % W)) % W);
      2: begin
        b = m_k % (2 * (W - 1));
        return rot_left(m_seed, (b <= W - 1) ? b : 2 * (W - 1) - b);
      end
      3: return (m_k % 2 == 1) ? ~m_seed : m_seed;
      default: return m_seed;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_seed = RST_PAT; m_mode = 0; m_period = DEF_PERIOD;
      m_count = 0; m_k = 0; m_tick = 0; m_valid = 1;
    end else if (cfg_load) begin
      m_seed = cfg_seed; m_mode = int'(cfg_mode); m_period = int'(cfg_period);
      m_count = 0; m_k = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (enable) begin
        if (m_count == m_period) begin
          m_count = 0; m_k++; m_tick = 1;
        end else begin
          m_count++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (led_out !== model_led()) begin
        n_fail++;
        $display("FAIL model_led t=%0t got=%h exp=%h", $time, led_out, model_led());
      end
      n_checks++;
      if (tick !== m_tick) begin
        n_fail++;
        $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick, m_tick);
      end
    end
  end

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(logic [2:0] mode, int period, logic [W-1:0] seed);
    cfg_mode = mode; cfg_period = CW'(period); cfg_seed = seed; cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cfg_load = 1'b0;
    cfg_mode = 3'd0; cfg_period = '0; cfg_seed = '0;
    cyc(2);
    check("reset_led", led_out, 16'hfffe);
    check("reset_tick", {15'd0, tick}, 16'd0);
    reset = 1'b0;

    load(3'd0, 3, 16'hfffe);
    cyc(4); check("rotl_s1", led_out, 16'hfffd); check("rotl_s1_tick", {15'd0, tick}, 16'd1);
    cyc(4); check("rotl_s2", led_out, 16'hfffb);
    cyc(4); check("rotl_s3", led_out, 16'hfff7);
    cyc(52); check("rotl_wrap", led_out, 16'hfffe);

    load(3'd1, 0, 16'hfffe);
    cyc(1); check("rotr_s1", led_out, 16'h7fff); check("rotr_tick", {15'd0, tick}, 16'd1);
    cyc(1); check("rotr_s2", led_out, 16'hbfff);
    cyc(1); check("rotr_s3", led_out, 16'hdfff);

    load(3'd2, 0, 16'hfffe);
    cyc(15); check("bounce_15", led_out, 16'h7fff);
    cyc(1);  check("bounce_16", led_out, 16'hbfff);
    cyc(14); check("bounce_30", led_out, 16'hfffe);
    cyc(1);  check("bounce_31", led_out, 16'hfffd);

    load(3'd3, 1, 16'h00ff);
    cyc(2); check("blink_1", led_out, 16'hff00); check("blink_tick", {15'd0, tick}, 16'd1);
    enable = 1'b0;
    cyc(5); check("blink_frozen", led_out, 16'hff00); check("frozen_tick", {15'd0, tick}, 16'd0);
    enable = 1'b1;
    cyc(2); check("blink_resume", led_out, 16'h00ff);

    load(3'd0, 2, 16'hfffe);
    cyc(2);
    load(3'd0, 2, 16'hf0f0);
    check("coll_led", led_out, 16'hf0f0); check("coll_tick", {15'd0, tick}, 16'd0);
    cyc(2); check("coll_wait", {15'd0, tick}, 16'd0);
    cyc(1); check("coll_step", led_out, 16'he1e1); check("coll_step_tick", {15'd0, tick}, 16'd1);

    load(3'd6, 1, 16'h1234);
    cyc(2); check("hold_led", led_out, 16'h1234); check("hold_tick", {15'd0, tick}, 16'd1);

    load(3'd2, 0, 16'hfffe);
    cyc(20);
    reset = 1'b1; cfg_load = 1'b1; cfg_seed = 16'habcd; cfg_mode = 3'd3;
    cyc(1);
    check("rst_led", led_out, 16'hfffe); check("rst_tick", {15'd0, tick}, 16'd0);
    reset = 1'b0; cfg_load = 1'b0;
    cyc(5); check("rst_noslowstep", led_out, 16'hfffe);

    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom % 8) != 0;
      cfg_load   = ($urandom % 20) == 0;
      cfg_mode   = 3'($urandom % 8);
      cfg_period = CW'($urandom % 4);
      cfg_seed   = W'($urandom);
      reset      = ($urandom % 400) == 0;
      cyc(1);
    end
    reset = 1'b0; cfg_load = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern.md
Name: led_pattern

Overview:
- Parametrised LED pattern generator driving an active-low LED bank (0 = lit).
- A programmable prescaler advances the pattern one step per period.
- Step modes: rotate left, rotate right, bounce (ping-pong), blink and hold.
- Top-level board glue. Configuration is loaded with a single strobe, from switches or a debug register.

Parameters:
- WIDTH, 16, number of LEDs; must be >= 2.
- COUNT_W, 27, width of prescaler counter and period input.
- DEFAULT_PERIOD, 27'd38_196_600, period loaded at reset (about 1 s on board clock).
- RESET_PATTERN, 16'hfffe, pattern loaded at reset (LED0 lit); width WIDTH.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = prescaler runs; 0 = counter and pattern freeze.
- cfg_load  in  1  single-cycle strobe; latches cfg_mode, cfg_period, cfg_seed.
- cfg_mode  in  3  0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK, 4 HOLD, 5-7 reserved (act as HOLD).
- cfg_period  in  COUNT_W  terminal count; step interval = cfg_period+1 cycles.
- cfg_seed  in  WIDTH  pattern loaded on cfg_load.
- led_out  out  WIDTH  registered LED pattern, active-low.
- tick  out  1  registered pulse, high in the cycle led_out shows a new step.

Behaviour:
- Reset (reset=1 at clock edge):
  - led_out = RESET_PATTERN, mode_r = ROTL, period_r = DEFAULT_PERIOD.
  - count = 0, pos = 0, dir = LEFT, tick = 0.
  - All state is synchronous; no asynchronous path.
- Prescaler:
  - When enable=1, count increments each cycle. When count == period_r, count wraps to 0 and a step fires on that edge.
  - period_r = 0 means a step every enabled cycle.
  - When enable=0, count holds and no step fires.
- Latency: after reset deasserts with enable=1, the first step is visible in led_out (with tick=1) on cycle period_r+1, counting the first non-reset cycle as 0.
- Step by mode:
  - ROTL: led_out <= {led_out[WIDTH-2:0], led_out[WIDTH-1]}.
  - ROTR: led_out <= {led_out[0], led_out[WIDTH-1:1]}.
  - BOUNCE: pos is a $clog2(WIDTH)-bit position and dir is a 1-bit direction.
    - dir=LEFT: rotate left, pos+1; if the new pos == WIDTH-1, dir <= RIGHT.
    - dir=RIGHT: rotate right, pos-1; if the new pos == 0, dir <= LEFT.
    - This gives WIDTH-1 steps each way. Endpoints are shown once, never repeated.
  - BLINK: led_out <= ~led_out.
  - HOLD / reserved: led_out unchanged, but tick still pulses on each step.
- tick is 1 for exactly one cycle per step, aligned with the updated led_out. It is 0 otherwise, and 0 in the cycle after cfg_load.
- cfg_load, effective on that edge:
  - mode_r, period_r and led_out take cfg_mode, cfg_period and cfg_seed.
  - count = 0, pos = 0, dir = LEFT.
  - It applies regardless of enable.
- Simultaneous events:
  - reset beats cfg_load, which beats a step. A step coinciding with cfg_load is discarded; no tick.
- Reset mid-operation restores all reset values on the next edge, independent of enable or cfg_load.
- Config inputs are ignored except in cycles where cfg_load=1.
- No width growth: count compare is COUNT_W wide, and rotations are modulo WIDTH.

Test Plan:
- Reset then release, enable=1, load period=3, seed=16'hfffe, mode ROTL:
  - led_out = fffd, fffb, fff7 at 4-cycle intervals, tick once per step.
  - After 16 steps the pattern returns to fffe.
- Mode ROTR, period=0, seed=16'hfffe:
  - led_out = 7fff, bfff, dfff on consecutive cycles, tick high every cycle.
- Mode BOUNCE, period=0, seed=16'hfffe:
  - Lit bit goes 0 -> 15 in 15 steps, then 15 -> 0 in 15 steps.
  - At step 15 the pattern is 7fff; at step 16 it is bfff; at step 30 it is fffe; at step 31 it is fffd.
- Mode BLINK, period=1, seed=16'h00ff:
  - led_out alternates ff00 and 00ff every 2 cycles.
  - Hold enable=0 for 5 cycles: led_out and the counter freeze, no tick. Resume continues the same phase.
- cfg_load asserted in the same cycle a step would fire (ROTL, period=2):
  - led_out = new seed, no tick that cycle, next step exactly 3 cycles later.
  - Mode 6 behaves as HOLD with tick still pulsing.
- reset asserted mid-BOUNCE while dir=RIGHT, together with cfg_load:
  - Next cycle led_out = fffe, tick = 0, period back to DEFAULT_PERIOD, mode ROTL.
